// File: rtl/bias_accum_relu_stage_pkg.sv
// Shared constants, result types and lane helpers for the bias/accumulate/ReLU stage.
package bias_accum_relu_stage_pkg;

    localparam int N_ADDER_TREE = 16;
    localparam int DW           = 18;
    localparam int MAX_GROUPS   = 64;
    localparam int CNT_W        = $clog2(MAX_GROUPS);
    localparam int ACC_W        = DW + CNT_W + 1;
    localparam int BUS_W        = N_ADDER_TREE * DW;

    localparam logic [DW-1:0] SAT_MAX = 18'h1FFFF;
    localparam logic [DW-1:0] SAT_MIN = 18'h20000;

    typedef struct packed {
        logic [DW-1:0] val;
        logic          clip;
    } sat_res_t;

    // In range exactly when every bit from the DW sign position upward agrees.
    function automatic sat_res_t sat_dw(input logic signed [ACC_W:0] x);
        sat_res_t r;
        logic [ACC_W-DW+1:0] hi;
        hi = x[ACC_W:DW-1];
        if ((&hi) || !(|hi)) begin
            r.val  = x[DW-1:0];
            r.clip = 1'b0;
        end else begin
            r.val  = x[ACC_W] ? SAT_MIN : SAT_MAX;
            r.clip = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] lane_slice(input logic [BUS_W-1:0] bus, input int unsigned idx);
        return bus[idx*DW +: DW];
    endfunction

endpackage

// File: rtl/bias_accum_relu_stage_if.sv
// Valid/ready lane stream carrying N_ADDER_TREE packed DW-bit lanes plus a last marker.
interface bias_accum_relu_stage_if
    import bias_accum_relu_stage_pkg::*;
#(
    parameter int W = BUS_W
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/bias_accum_relu_stage_lane.sv
// One lane: running partial-sum accumulator, bias add, saturation and optional ReLU.
module bias_lane_acc
    import bias_accum_relu_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          accept_i,
    input  logic          last_i,
    input  logic          first_i,
    input  logic          relu_en_i,
    input  logic [DW-1:0] in_lane_i,
    input  logic [DW-1:0] bias_lane_i,
    output logic [DW-1:0] res_o,
    output logic          clip_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_base_s;
    logic signed [ACC_W-1:0] acc_next_s;
    logic signed [ACC_W:0]   sum_s;
    sat_res_t                sat_s;
    logic [DW-1:0]           res_q;
    logic [DW-1:0]           res_d;

    // Next accumulator and finished result; a first beat ignores stale accumulator contents.
    always_comb begin
        acc_base_s = first_i ? {ACC_W{1'b0}} : acc_q;
        acc_next_s = acc_base_s + {{(ACC_W-DW){in_lane_i[DW-1]}}, in_lane_i};
        sum_s      = {acc_next_s[ACC_W-1], acc_next_s}
                   + {{(ACC_W+1-DW){bias_lane_i[DW-1]}}, bias_lane_i};
        sat_s      = sat_dw(sum_s);
        acc_d      = acc_q;
        res_d      = res_q;
        clip_o     = 1'b0;
        if (accept_i) begin
            if (last_i) begin
                acc_d  = {ACC_W{1'b0}};
                res_d  = (relu_en_i && sat_s.val[DW-1]) ? {DW{1'b0}} : sat_s.val;
                clip_o = sat_s.clip;
            end else begin
                acc_d = acc_next_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= {ACC_W{1'b0}};
            res_q <= {DW{1'b0}};
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/bias_accum_relu_stage.sv
// Accumulates adder-tree partial sums per pixel, adds bias, saturates, optional ReLU.
module bias_accum_relu_stage
    import bias_accum_relu_stage_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    bias_accum_relu_stage_if.slave         in_if,
    bias_accum_relu_stage_if.master        out_if,
    input  logic [BUS_W-1:0]               bias_i,
    input  logic                           relu_en_i,
    output logic                           sat_flag_o,
    output logic                           grp_err_o
);

    logic                    in_ready_s;
    logic                    accept_s;
    logic                    first_s;
    logic [N_ADDER_TREE-1:0] clip_s;
    logic [BUS_W-1:0]        out_data_s;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    out_valid_q;
    logic                    out_valid_d;
    logic                    sat_flag_q;
    logic                    sat_flag_d;
    logic                    grp_err_q;
    logic                    grp_err_d;

    assign in_ready_s = !out_valid_q || out_if.ready;
    assign accept_s   = in_if.valid && in_ready_s;
    assign first_s    = (cnt_q == {CNT_W{1'b0}});

    for (genvar g = 0; g < N_ADDER_TREE; g++) begin : g_lane
        bias_lane_acc u_lane (
            .clk         (clk),
            .rst         (rst),
            .accept_i    (accept_s),
            .last_i      (in_if.last),
            .first_i     (first_s),
            .relu_en_i   (relu_en_i),
            .in_lane_i   (lane_slice(in_if.data, g)),
            .bias_lane_i (lane_slice(bias_i, g)),
            .res_o       (out_data_s[g*DW +: DW]),
            .clip_o      (clip_s[g])
        );
    end

    // Beat counter, output valid and sticky flags; the counter pins at MAX_GROUPS-1 on overrun.
    always_comb begin
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        sat_flag_d  = sat_flag_q | (|clip_s);
        grp_err_d   = grp_err_q;
        if (accept_s && in_if.last) begin
            cnt_d       = {CNT_W{1'b0}};
            out_valid_d = 1'b1;
        end else if (accept_s) begin
            if (cnt_q == CNT_W'(MAX_GROUPS - 1)) begin
                grp_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (out_if.ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end else if (out_if.ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            sat_flag_q  <= 1'b0;
            grp_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            sat_flag_q  <= sat_flag_d;
            grp_err_q   <= grp_err_d;
        end
    end

    assign in_if.ready  = in_ready_s;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = out_data_s;
    assign out_if.last  = 1'b1;
    assign sat_flag_o   = sat_flag_q;
    assign grp_err_o    = grp_err_q;

endmodule
